// File: rtl/stim_sequencer_if.sv
// Host-side configuration and control bundle for stim_sequencer.
// The host (okWireIn/okTriggerIn side) is the master; the sequencer is the slave.
interface stim_sequencer_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32,
  parameter int unsigned TW = 16
);
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_current;
  logic [TW-1:0] cfg_dwell;
  logic [AW:0]   num_steps;
  logic          loop_en;
  logic          start;
  logic          stop;
  logic [DW-1:0] default_current;

  modport master (
    output cfg_we, cfg_addr, cfg_current, cfg_dwell,
    output num_steps, loop_en, start, stop, default_current
  );

  modport slave (
    input cfg_we, cfg_addr, cfg_current, cfg_dwell,
    input num_steps, loop_en, start, stop, default_current
  );
endinterface

// File: rtl/stim_sequencer.sv
// Programmable current-stimulus sequencer: plays a (current, dwell) table on
// simulation-millisecond ticks and drives the neuron's I_in.
module stim_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned TW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tick,
  stim_sequencer_if.slave host,
  output logic [DW-1:0] I_out,
  output logic [AW-1:0] step_idx,
  output logic          step_strobe,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [1:0]    state;
  logic [TW-1:0] cnt;
  logic [AW:0]   nsteps;
  logic          loop_lat;

  logic [DW-1:0] cur_mem   [DEPTH];
  logic [TW-1:0] dwell_mem [DEPTH];

  logic          idle_like;
  logic          last_step;
  logic [AW-1:0] next_idx;
  logic [TW-1:0] next_dwell;
  logic [TW-1:0] first_dwell;
  logic [AW:0]   nsteps_clamped;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);

  always_comb begin
    last_step      = ({1'b0, step_idx} + (AW+1)'(1)) >= nsteps;
    next_idx       = last_step ? '0 : step_idx + AW'(1);
    // A zero dwell still holds its entry for one tick.
    next_dwell     = (dwell_mem[next_idx] == '0) ? TW'(1) : dwell_mem[next_idx];
    first_dwell    = (dwell_mem[0] == '0) ? TW'(1) : dwell_mem[0];
    nsteps_clamped = (host.num_steps > DEPTH_W) ? DEPTH_W : host.num_steps;
  end

  // Table storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (host.cfg_we && idle_like) begin
      cur_mem[host.cfg_addr]   <= host.cfg_current;
      dwell_mem[host.cfg_addr] <= host.cfg_dwell;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      I_out       <= '0;
      step_idx    <= '0;
      step_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cnt         <= '0;
      nsteps      <= '0;
      loop_lat    <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      if (host.stop) begin
        state <= S_IDLE;
        I_out <= host.default_current;
        cnt   <= '0;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            I_out <= host.default_current;
            if (host.start && (host.num_steps != '0)) begin
              state    <= S_ARM;
              nsteps   <= nsteps_clamped;
              loop_lat <= host.loop_en;
              busy     <= 1'b1;
              done     <= 1'b0;
            end
          end
          S_ARM: begin
            if (tick) begin
              I_out       <= cur_mem[0];
              cnt         <= first_dwell;
              step_idx    <= '0;
              step_strobe <= 1'b1;
              state       <= S_RUN;
            end
          end
          S_RUN: begin
            if (tick) begin
              if (cnt > TW'(1)) begin
                cnt <= cnt - TW'(1);
              end else if (!last_step || loop_lat) begin
                // next_idx already wraps to 0 on the last entry when looping.
                step_idx    <= next_idx;
                I_out       <= cur_mem[next_idx];
                cnt         <= next_dwell;
                step_strobe <= 1'b1;
              end else begin
                state <= S_DONE;
                I_out <= host.default_current;
                cnt   <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed self-checking bench for stim_sequencer.
module tb_stim_sequencer;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned TW    = 16;
  localparam int DEF = 10240;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick    = 1'b0;
  logic [DW-1:0] I_out;
  logic [AW-1:0] step_idx;
  logic          step_strobe;
  logic          busy;
  logic          done;

  int vectors     = 0;
  int miscompares = 0;

  int pat_i [6] = '{1000, 1000, 2000, 2000, 2000, 3000};
  int pat_x [6] = '{0, 0, 1, 1, 1, 2};
  int pat_s [6] = '{1, 0, 1, 0, 0, 1};

  always #5 clk = ~clk;

  stim_sequencer_if #(.AW(AW), .DW(DW), .TW(TW)) bus ();

  stim_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .TW(TW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .host       (bus),
    .I_out      (I_out),
    .step_idx   (step_idx),
    .step_strobe(step_strobe),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int cur, input int dw);
    bus.cfg_we      = 1'b1;
    bus.cfg_addr    = AW'(addr);
    bus.cfg_current = DW'(cur);
    bus.cfg_dwell   = TW'(dw);
    cyc();
    bus.cfg_we      = 1'b0;
  endtask

  task automatic start_pulse(input int ns, input logic lp);
    bus.num_steps = (AW+1)'(ns);
    bus.loop_en   = lp;
    bus.start     = 1'b1;
    cyc();
    bus.start     = 1'b0;
  endtask

  task automatic stop_pulse();
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
  endtask

  // One quiet cycle, then a tick; checks outputs after the tick edge.
  task automatic exp_tick(input string tag, input int i_exp, input int idx_exp, input int s_exp);
    cyc();
    chk({tag, ".strobe_quiet"}, step_strobe, 0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk({tag, ".I_out"}, I_out, i_exp);
    chk({tag, ".strobe"}, step_strobe, s_exp);
    if (idx_exp >= 0) chk({tag, ".step_idx"}, step_idx, idx_exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_current = '0; bus.cfg_dwell = '0;
    bus.num_steps = '0; bus.loop_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.default_current = DW'(DEF);

    // Reset values, then default current one clk after release
    repeat (2) cyc();
    chk("rst.I_out", I_out, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.step_idx", step_idx, 0);
    chk("rst.strobe", step_strobe, 0);
    reset_n = 1'b1;
    cyc();
    chk("rel.I_out", I_out, DEF);
    chk("rel.busy", busy, 0);
    chk("rel.done", done, 0);

    // Single pass, no loop
    wr(0, 1000, 2); wr(1, 2000, 3); wr(2, 3000, 1);
    start_pulse(3, 1'b0);
    chk("arm.busy", busy, 1);
    chk("arm.I_out", I_out, DEF);
    exp_tick("p1", 1000, 0, 1);
    exp_tick("p2", 1000, 0, 0);
    exp_tick("p3", 2000, 1, 1);
    exp_tick("p4", 2000, 1, 0);
    exp_tick("p5", 2000, 1, 0);
    exp_tick("p6", 3000, 2, 1);
    exp_tick("p7", DEF, -1, 0);
    chk("p.done", done, 1);
    chk("p.busy", busy, 0);

    // Looping for 20 ticks
    start_pulse(3, 1'b1);
    for (int k = 0; k < 20; k++) begin
      exp_tick("loop", pat_i[k % 6], pat_x[k % 6], pat_s[k % 6]);
      chk("loop.busy", busy, 1);
    end
    exp_tick("loop21", 2000, 1, 1);
    exp_tick("loop22", 2000, 1, 0);

    // Stop mid-dwell of step 1
    stop_pulse();
    chk("stop.I_out", I_out, DEF);
    chk("stop.busy", busy, 0);
    chk("stop.done", done, 0);

    // Start and stop together: stop wins
    bus.num_steps = 5'd3;
    bus.start = 1'b1; bus.stop = 1'b1;
    cyc();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("ss.busy", busy, 0);
    exp_tick("ss.tick", DEF, -1, 0);
    chk("ss.busy2", busy, 0);

    // Start with tick in the same cycle only arms
    bus.num_steps = 5'd3; bus.loop_en = 1'b0;
    bus.start = 1'b1; tick = 1'b1;
    cyc();
    bus.start = 1'b0; tick = 1'b0;
    chk("st.busy", busy, 1);
    chk("st.I_out", I_out, DEF);
    chk("st.strobe", step_strobe, 0);
    exp_tick("st.first", 1000, 0, 1);
    stop_pulse();
    chk("st.stop.busy", busy, 0);

    // num_steps == 0 is ignored
    start_pulse(0, 1'b0);
    chk("z.busy", busy, 0);
    chk("z.done", done, 0);
    exp_tick("z.tick", DEF, -1, 0);
    chk("z.busy2", busy, 0);

    // Clamp to DEPTH, zero dwell lasts one tick
    for (int i = 0; i < 16; i++) wr(i, 5000 + i, (i == 0 || i == 5) ? 0 : 1);
    start_pulse(20, 1'b0);
    for (int k = 0; k < 16; k++) exp_tick("clamp", 5000 + k, k, 1);
    exp_tick("clamp.end", DEF, -1, 0);
    chk("clamp.done", done, 1);

    // Writes during RUN are ignored
    wr(0, 1000, 2); wr(1, 2000, 3); wr(2, 3000, 1);
    start_pulse(3, 1'b0);
    exp_tick("w1", 1000, 0, 1);
    exp_tick("w2", 1000, 0, 0);
    wr(1, 7777, 9);
    chk("w.busy", busy, 1);
    exp_tick("w3", 2000, 1, 1);
    exp_tick("w4", 2000, 1, 0);
    exp_tick("w5", 2000, 1, 0);
    exp_tick("w6", 3000, 2, 1);
    exp_tick("w7", DEF, -1, 0);
    chk("w.done", done, 1);

    // Asynchronous reset mid-run
    start_pulse(3, 1'b0);
    exp_tick("r1", 1000, 0, 1);
    exp_tick("r2", 1000, 0, 0);
    exp_tick("r3", 2000, 1, 1);
    reset_n = 1'b0;
    #1;
    chk("ar.I_out", I_out, 0);
    chk("ar.step_idx", step_idx, 0);
    chk("ar.strobe", step_strobe, 0);
    chk("ar.busy", busy, 0);
    chk("ar.done", done, 0);
    cyc();
    chk("ar.hold.I_out", I_out, 0);
    reset_n = 1'b1;
    cyc();
    chk("ar.rel.I_out", I_out, DEF);
    chk("ar.rel.busy", busy, 0);

    // Replay: table survives reset and the ignored write
    start_pulse(3, 1'b0);
    exp_tick("rp1", 1000, 0, 1);
    exp_tick("rp2", 1000, 0, 0);
    exp_tick("rp3", 2000, 1, 1);
    exp_tick("rp4", 2000, 1, 0);
    exp_tick("rp5", 2000, 1, 0);
    exp_tick("rp6", 3000, 2, 1);
    exp_tick("rp7", DEF, -1, 0);
    chk("rp.done", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
